bcd_field_counter: RTL
======================

Name: bcd_field_counter

Overview:
Parametrised BCD up/down counter for one calendar/clock field (day, month, hour, minute, ...) in the RTC display/set path. It tracks the RTC value while not in edit mode. In edit mode it steps within a configurable [MIN_VAL, MAX_VAL] range, with an optional run-time upper limit for days-per-month. It adds:
- edge-detected key stepping with auto-repeat;
- carry/borrow pulses for cascading fields;
- validation of loaded values.

Parameters:
DIGITS, 2, number of BCD digits; W = 4*DIGITS.
MIN_VAL, 1, lowest field value (decimal integer).
MAX_VAL, 31, highest field value (decimal integer); MIN_VAL < MAX_VAL < 10**DIGITS.
USE_DYN_MAX, 1, 1 = max_dyn input limits the range; 0 = max_dyn ignored.
REPEAT_DELAY, 0, 0 = level mode (one step per clk while key held); >0 = cycles from first step to second step while a key is held.
REPEAT_RATE, 1, cycles between subsequent repeat steps (>=1; used only when REPEAT_DELAY>0).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = edit mode (keys step the counter); 0 = track dato_rtc
up  in  1  increment key
down  in  1  decrement key
dato_rtc  in  W  BCD value from RTC, loaded while enable=0
max_dyn  in  W  BCD run-time upper limit (e.g. 0x28/0x29/0x30/0x31)
out  out  W  current BCD value, registered
carry  out  1  one-cycle pulse on MAX->MIN wrap
borrow  out  1  one-cycle pulse on MIN->MAX wrap
load_err  out  1  registered flag: the last load cycle saw an invalid or out-of-range dato_rtc

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high. All state changes on posedge clk.
- Reset values: out = BCD(MIN_VAL); carry = borrow = load_err = 0; key-edge registers and repeat counters = 0.
- Effective max EMAX:
  - if USE_DYN_MAX = 1 and max_dyn is valid BCD with BCD(MIN_VAL) <= max_dyn <= BCD(MAX_VAL), then EMAX = max_dyn;
  - otherwise EMAX = BCD(MAX_VAL).
- Per-cycle priority: reset > load (enable=0) > up and down both asserted (hold; repeat state cleared) > up step > down step > range clamp.
- Load (enable=0):
  - Repeat state is cleared.
  - dato_rtc has any digit > 9: out unchanged, load_err = 1.
  - dato_rtc valid but < MIN: out = MIN, load_err = 1.
  - dato_rtc valid but > EMAX: out = EMAX, load_err = 1.
  - Otherwise: out = dato_rtc, load_err = 0.
  - Whenever enable=1, load_err = 0.
- Step up: if out >= EMAX, out = MIN and carry = 1 for exactly one cycle. Otherwise BCD increment: low digit 9 -> 0 with ripple into higher digits.
- Step down:
  - if out > EMAX, out = EMAX, no borrow;
  - else if out <= MIN, out = EMAX and borrow = 1 for one cycle;
  - otherwise BCD decrement: digit 0 -> 9 with borrow ripple.
- Range clamp: with enable=1 and no step this cycle, if out > EMAX then out = EMAX on the next edge. This covers max_dyn dropping from 31 to 30, for example.
- Step generation with REPEAT_DELAY = 0: a step occurs every cycle the key is asserted. This is legacy level behaviour.
- Step generation with REPEAT_DELAY > 0, per key:
  - The first step occurs in the cycle the key is first seen high (registered previous sample = 0).
  - While the key is held, the second step occurs REPEAT_DELAY cycles later.
  - Further steps follow every REPEAT_RATE cycles.
  - Releasing the key, enable=0, both keys high, or reset returns the key to idle.
- Latency: out reflects a step, load or clamp one clk after the qualifying cycle. carry/borrow are asserted in the same cycle that out shows the wrapped value.
- Only valid BCD values within [MIN, EMAX] are produced by steps. Any out value is reachable only by reset, load, step or clamp.

Decomposition:
- Package bcd_pkg:
  - functions bcd_valid, bcd_inc, bcd_dec, bcd_gt/bcd_lt (digit-wise compare), int_to_bcd (elaborates MIN/MAX constants);
  - localparam W.
- One sub-module, bcd_key_repeat:
  - edge detect plus delay/rate counter;
  - parameters REPEAT_DELAY and REPEAT_RATE;
  - ports clk, reset, clr, key_in, step_out;
  - instantiated twice, once for up and once for down.

Test Plan:
1. Defaults; assert reset for 2 cycles -> out = 0x01, carry = borrow = load_err = 0. Assert reset mid-step sequence at out = 0x17 -> out = 0x01 next cycle.
2. Level mode, enable=1, max_dyn=0x31, load 0x29, then up for 3 cycles -> out 0x30, 0x31, 0x01. carry is high only in the 0x01 cycle.
3. max_dyn=0x28, out=0x01, down one cycle -> out = 0x28, borrow pulse. Next down -> 0x27, borrow = 0.
4. enable=0 with dato_rtc = 0x3A -> out unchanged, load_err=1. dato_rtc = 0x35 -> out=0x31, load_err=1. dato_rtc = 0x00 -> out=0x01, load_err=1. dato_rtc = 0x15 -> out=0x15, load_err=0.
5. out=0x31, enable=1, max_dyn changes to 0x30, no key -> out = 0x30 next cycle. max_dyn=0x45 (> MAX) -> EMAX = 0x31. up and down both held -> out constant.
6. REPEAT_DELAY=4, REPEAT_RATE=2, out=0x05, up held 9 cycles (t0..t8) -> steps at t0, t4, t6, t8, final out=0x09. Release for 1 cycle, then re-press -> immediate single step to 0x10.

Source files
------------

// File: rtl/bcd_pkg.sv
// BCD helper package for the calendar/clock field counter.
// All helpers work on a fixed-width container (BCD_W bits, up to
// MAX_DIGITS digits); callers zero-extend their narrower fields into it.
package bcd_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int BCD_W      = 4 * MAX_DIGITS;

    typedef logic [BCD_W-1:0] bcd_t;

    // True when every nibble is a legal decimal digit.
    function automatic logic bcd_valid(input bcd_t v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // BCD increment; a 9 rolls to 0 and ripples a carry into the next digit.
    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t r;
        logic c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (c && (v[4*i +: 4] == 4'd9)) begin
                r[4*i +: 4] = 4'd0;
            end else if (c) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                c = 1'b0;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // BCD decrement; a 0 rolls to 9 and ripples a borrow into the next digit.
    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        logic b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (b && (v[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'd9;
            end else if (b) begin
                r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                b = 1'b0;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Digit-wise a > b: the most significant differing digit decides.
    function automatic logic bcd_gt(input bcd_t a, input bcd_t b);
        logic res;
        logic done;
        res  = 1'b0;
        done = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!done && (a[4*i +: 4] != b[4*i +: 4])) begin
                res  = (a[4*i +: 4] > b[4*i +: 4]);
                done = 1'b1;
            end else begin
                res  = res;
                done = done;
            end
        end
        return res;
    endfunction

    // Digit-wise a < b.
    function automatic logic bcd_lt(input bcd_t a, input bcd_t b);
        return bcd_gt(b, a);
    endfunction

    // Decimal integer to packed BCD; used to elaborate MIN/MAX constants.
    function automatic bcd_t int_to_bcd(input int n);
        bcd_t r;
        int   v;
        r = '0;
        v = n;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_key_repeat.sv
// Key edge detector with optional auto-repeat.
// REPEAT_DELAY = 0: step_out follows the key level every cycle.
// REPEAT_DELAY > 0: step on the first high sample, again REPEAT_DELAY
// cycles later, then every REPEAT_RATE cycles while the key stays held.
// step_out is combinational so the counter can act on it in the same cycle.
module bcd_key_repeat #(
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic key_in,
    output logic step_out
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic          prev_q;
    logic          prev_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next-state for the edge register and repeat counter, plus the step strobe.
    always_comb begin
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        step_out = 1'b0;
        if (clr || !key_in) begin
            prev_d   = 1'b0;
            cnt_d    = CW'(0);
            step_out = 1'b0;
        end else if (REPEAT_DELAY == 0) begin
            prev_d   = 1'b1;
            cnt_d    = CW'(0);
            step_out = 1'b1;
        end else if (!prev_q) begin
            prev_d   = 1'b1;
            cnt_d    = CW'(REPEAT_DELAY - 1);
            step_out = 1'b1;
        end else if (cnt_q == CW'(0)) begin
            cnt_d    = CW'(REPEAT_RATE - 1);
            step_out = 1'b1;
        end else begin
            cnt_d    = cnt_q - CW'(1);
            step_out = 1'b0;
        end
    end

    // Edge register and repeat counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            cnt_q  <= CW'(0);
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_field_counter.sv
// BCD up/down counter for one calendar/clock field. Tracks dato_rtc while
// enable=0 (with validation), steps within [MIN, EMAX] on keys while
// enable=1, and emits carry/borrow pulses on wrap for field cascading.
// DIGITS must not exceed bcd_pkg::MAX_DIGITS.
module bcd_field_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS       = 2,
    parameter int MIN_VAL      = 1,
    parameter int MAX_VAL      = 31,
    parameter int USE_DYN_MAX  = 1,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                up,
    input  logic                down,
    input  logic [4*DIGITS-1:0] dato_rtc,
    input  logic [4*DIGITS-1:0] max_dyn,
    output logic [4*DIGITS-1:0] out,
    output logic                carry,
    output logic                borrow,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    localparam bcd_t MIN_EXT = int_to_bcd(MIN_VAL);
    localparam bcd_t MAX_EXT = int_to_bcd(MAX_VAL);
    localparam logic [W-1:0] MIN_BCD = MIN_EXT[W-1:0];
    localparam logic [W-1:0] MAX_BCD = MAX_EXT[W-1:0];

    logic [W-1:0] out_q;
    logic [W-1:0] out_d;
    logic         carry_q;
    logic         carry_d;
    logic         borrow_q;
    logic         borrow_d;
    logic         load_err_q;
    logic         load_err_d;

    logic         key_clr_s;
    logic         up_step_s;
    logic         dn_step_s;
    logic         dyn_ok_s;
    logic [W-1:0] emax_s;
    bcd_t         out_ext_s;
    bcd_t         emax_ext_s;
    bcd_t         dato_ext_s;
    bcd_t         dyn_ext_s;

    // Repeat state returns to idle when loading or when both keys are held.
    assign key_clr_s = ~enable | (up & down);

    bcd_key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_up (
        .clk      (clk),
        .reset    (reset),
        .clr      (key_clr_s),
        .key_in   (up),
        .step_out (up_step_s)
    );

    bcd_key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_dn (
        .clk      (clk),
        .reset    (reset),
        .clr      (key_clr_s),
        .key_in   (down),
        .step_out (dn_step_s)
    );

    // Effective upper limit: max_dyn only when it is legal BCD inside [MIN, MAX].
    always_comb begin
        dyn_ext_s = BCD_W'(max_dyn);
        dyn_ok_s  = 1'b0;
        emax_s    = MAX_BCD;
        if ((USE_DYN_MAX != 0) && bcd_valid(dyn_ext_s) &&
            !bcd_lt(dyn_ext_s, MIN_EXT) && !bcd_gt(dyn_ext_s, MAX_EXT)) begin
            dyn_ok_s = 1'b1;
            emax_s   = max_dyn;
        end else begin
            dyn_ok_s = 1'b0;
            emax_s   = MAX_BCD;
        end
    end

    // Next value of the field: load > both-keys hold > up > down > clamp.
    always_comb begin
        out_ext_s  = BCD_W'(out_q);
        emax_ext_s = BCD_W'(emax_s);
        dato_ext_s = BCD_W'(dato_rtc);
        out_d      = out_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (!enable) begin
            if (!bcd_valid(dato_ext_s)) begin
                out_d      = out_q;
                load_err_d = 1'b1;
            end else if (bcd_lt(dato_ext_s, MIN_EXT)) begin
                out_d      = MIN_BCD;
                load_err_d = 1'b1;
            end else if (bcd_gt(dato_ext_s, emax_ext_s)) begin
                out_d      = emax_s;
                load_err_d = 1'b1;
            end else begin
                out_d      = dato_rtc;
                load_err_d = 1'b0;
            end
        end else if (up && down) begin
            out_d = out_q;
        end else if (up_step_s) begin
            if (!bcd_lt(out_ext_s, emax_ext_s)) begin
                out_d   = MIN_BCD;
                carry_d = 1'b1;
            end else begin
                out_d   = W'(bcd_inc(out_ext_s));
            end
        end else if (dn_step_s) begin
            if (bcd_gt(out_ext_s, emax_ext_s)) begin
                out_d    = emax_s;
            end else if (!bcd_gt(out_ext_s, MIN_EXT)) begin
                out_d    = emax_s;
                borrow_d = 1'b1;
            end else begin
                out_d    = W'(bcd_dec(out_ext_s));
            end
        end else if (bcd_gt(out_ext_s, emax_ext_s)) begin
            out_d = emax_s;
        end else begin
            out_d = out_q;
        end
    end

    // Field value and status flags, synchronous reset to MIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= MIN_BCD;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign out      = out_q;
    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign load_err = load_err_q;

endmodule
